fifo_stream_reader: RTL and testbench

Read-side engine for a standard-mode (non-FWFT) single-clock DPRAM FIFO. Drives the FIFO's read enable, absorbs the one-cycle read latency in a 2-entry skid buffer, and presents words downstream on a valid/ready stream. The stream carries packet framing (`o_Last`) and a delivered-word count. It sits between a FIFO read port and any consumer that can apply backpressure.

---
 rtl/fifo_stream_reader_if.sv | 23 ++
 rtl/fifo_stream_reader.sv | 103 ++++++++++
 tb/tb_fifo_stream_reader.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_stream_reader_if.sv
// Handshake bundle between the reader engine, the FIFO read port and the
// downstream stream consumer. The master side is the reader engine.
interface fifo_stream_reader_if #(
  parameter int WIDTH = 8
);
  logic             o_Rd_En;
  logic [WIDTH-1:0] i_Rd_Data;
  logic             i_Fifo_Empty;
  logic             o_DV;
  logic [WIDTH-1:0] o_Data;
  logic             o_Last;
  logic             i_Ready;

  modport master (
    output o_Rd_En, o_DV, o_Data, o_Last,
    input  i_Rd_Data, i_Fifo_Empty, i_Ready
  );

  modport slave (
    input  o_Rd_En, o_DV, o_Data, o_Last,
    output i_Rd_Data, i_Fifo_Empty, i_Ready
  );
endinterface

// File: rtl/fifo_stream_reader.sv
// Read engine for a standard-mode FIFO: credit-based read issue, 2-entry skid
// buffer absorbing the read latency, and packet framing on the output stream.
module fifo_stream_reader #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst_L,
  input  logic                 i_Enable,
  input  logic [CNT_W-1:0]     i_Pkt_Len,
  fifo_stream_reader_if.master bus,
  output logic [CNT_W-1:0]     o_Word_Count,
  output logic                 o_Busy
);

  localparam logic [0:0] FIRST = 1'b0;
  localparam logic [0:0] MID   = 1'b1;

  logic [1:0]       occ;
  logic             inflight;
  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] tail;
  logic [0:0]       state;
  logic [CNT_W-1:0] len;
  logic [CNT_W-1:0] pos;
  logic [CNT_W-1:0] word_count;
  logic             pop;
  logic [2:0]       credit;
  logic             last_raw;

  assign pop    = bus.o_DV & bus.i_Ready;
  // Pop never exceeds occupancy, so this difference cannot go negative.
  assign credit = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};

  assign bus.o_Rd_En = i_Rst_L & i_Enable & ~bus.i_Fifo_Empty & (credit < 3'd2);
  assign bus.o_DV    = (occ != 2'd0);
  assign bus.o_Data  = head;
  assign o_Busy      = inflight | (occ != 2'd0);
  assign o_Word_Count = word_count;

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      occ      <= 2'd0;
      inflight <= 1'b0;
    end else begin
      inflight <= bus.o_Rd_En;
      case ({inflight, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  // Head/tail storage needs no reset: occupancy alone says what is valid.
  always_ff @(posedge i_Clk) begin
    case ({inflight, pop})
      2'b10: begin
        if (occ == 2'd0) head <= bus.i_Rd_Data;
        else             tail <= bus.i_Rd_Data;
      end
      2'b01: head <= tail;
      2'b11: begin
        if (occ == 2'd1) begin
          head <= bus.i_Rd_Data;
        end else begin
          head <= tail;
          tail <= bus.i_Rd_Data;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    last_raw = 1'b0;
    if (state == FIRST) last_raw = (i_Pkt_Len == CNT_W'(1));
    else                last_raw = (pos == len - CNT_W'(1));
  end

  assign bus.o_Last = bus.o_DV & last_raw;

  // Packet length is latched on the first pop of each packet only.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      state      <= FIRST;
      len        <= '0;
      pos        <= '0;
      word_count <= '0;
    end else if (pop) begin
      word_count <= word_count + CNT_W'(1);
      if (state == FIRST) begin
        len <= i_Pkt_Len;
        pos <= CNT_W'(1);
        if (i_Pkt_Len > CNT_W'(1)) state <= MID;
      end else begin
        pos <= pos + CNT_W'(1);
        if (pos == len - CNT_W'(1)) state <= FIRST;
      end
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench: a behavioural standard-mode FIFO feeds the reader, a
// negedge monitor records every accepted word and protocol violations.
module tb_fifo_stream_reader;

  logic        clk = 1'b0;
  logic        rst_l;
  logic        enable;
  logic [15:0] pkt_len;
  logic [15:0] word_count;
  logic        busy;

  always #5 clk = ~clk;

  fifo_stream_reader_if #(.WIDTH(8)) bus ();

  fifo_stream_reader #(.WIDTH(8), .CNT_W(16)) dut (
    .i_Clk        (clk),
    .i_Rst_L      (rst_l),
    .i_Enable     (enable),
    .i_Pkt_Len    (pkt_len),
    .bus          (bus),
    .o_Word_Count (word_count),
    .o_Busy       (busy)
  );

  logic [7:0] fifo_mem [256];
  logic [7:0] fifo_wr_ptr;
  logic [7:0] fifo_rd_ptr;
  logic [8:0] fifo_count;
  logic [7:0] fifo_rd_data;
  logic       fifo_wr_en;
  logic [7:0] fifo_wr_data;
  logic       wr_ok;
  logic       rd_ok;

  assign wr_ok            = fifo_wr_en && (fifo_count != 9'd256);
  assign rd_ok            = bus.o_Rd_En && (fifo_count != 9'd0);
  assign bus.i_Fifo_Empty = (fifo_count == 9'd0);
  assign bus.i_Rd_Data    = fifo_rd_data;

  always @(posedge clk) begin
    if (!rst_l) begin
      fifo_wr_ptr <= 8'd0;
      fifo_rd_ptr <= 8'd0;
      fifo_count  <= 9'd0;
    end else begin
      if (wr_ok) begin
        fifo_mem[fifo_wr_ptr] <= fifo_wr_data;
        fifo_wr_ptr <= fifo_wr_ptr + 8'd1;
      end
      if (rd_ok) begin
        fifo_rd_data <= fifo_mem[fifo_rd_ptr];
        fifo_rd_ptr  <= fifo_rd_ptr + 8'd1;
      end
      fifo_count <= fifo_count + {8'd0, wr_ok} - {8'd0, rd_ok};
    end
  end

  int cycle_num = 0;
  always @(posedge clk) cycle_num <= cycle_num + 1;

  logic [7:0] rx_data [512];
  logic       rx_last [512];
  int rx_count, rd_en_count, last_total;
  int empty_read_err, full_read_err, overflow_err;
  int first_rd_cycle, first_pop_cycle, last_pop_cycle;

  always @(negedge clk) begin
    if (!rst_l) begin
      rx_count       <= 0;
      rd_en_count    <= 0;
      last_total     <= 0;
      empty_read_err <= 0;
      full_read_err  <= 0;
      overflow_err   <= 0;
    end else begin
      if (bus.o_Rd_En) begin
        if (rd_en_count == 0) first_rd_cycle <= cycle_num;
        rd_en_count <= rd_en_count + 1;
      end
      if (bus.o_Rd_En && bus.i_Fifo_Empty) empty_read_err <= empty_read_err + 1;
      if (bus.o_Rd_En && dut.occ == 2'd2 && !bus.i_Ready) full_read_err <= full_read_err + 1;
      if (dut.occ == 2'd3 || (dut.occ == 2'd2 && dut.inflight && !(bus.o_DV && bus.i_Ready)))
        overflow_err <= overflow_err + 1;
      if (bus.o_DV && bus.i_Ready) begin
        if (rx_count < 512) begin
          rx_data[rx_count] <= bus.o_Data;
          rx_last[rx_count] <= bus.o_Last;
        end
        if (rx_count == 0) first_pop_cycle <= cycle_num;
        last_pop_cycle <= cycle_num;
        if (bus.o_Last) last_total <= last_total + 1;
        rx_count <= rx_count + 1;
      end
    end
  end

  int check_count = 0;
  int error_count = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic doReset();
    bus.i_Ready = 1'b0;
    rst_l = 1'b0;
    tick();
    rst_l = 1'b1;
  endtask

  task automatic pushWords(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      fifo_wr_en   = 1'b1;
      fifo_wr_data = 8'(base + i);
      tick();
    end
    fifo_wr_en = 1'b0;
  endtask

  task automatic waitRx(input int n, input int budget, input string tag);
    int k = 0;
    while (rx_count < n && k < budget) begin
      tick();
      k++;
    end
    checkOutput(tag, 32'(rx_count), 32'(n));
  endtask

  task automatic checkStream(input int n, input int base, input string tag);
    for (int i = 0; i < n; i++)
      checkOutput($sformatf("%s_word%0d", tag, i), {24'd0, rx_data[i]}, 32'((base + i) & 8'hFF));
  endtask

  task automatic applyStimulus();
    logic [31:0] mask;

    rst_l = 1'b0; enable = 1'b0; pkt_len = 16'd0;
    bus.i_Ready = 1'b0; fifo_wr_en = 1'b0; fifo_wr_data = 8'd0;
    settle(2);
    rst_l = 1'b1;
    checkOutput("rst_dv",    32'(bus.o_DV), 32'd0);
    checkOutput("rst_last",  32'(bus.o_Last), 32'd0);
    checkOutput("rst_rd_en", 32'(bus.o_Rd_En), 32'd0);
    checkOutput("rst_busy",  32'(busy), 32'd0);
    checkOutput("rst_count", 32'(word_count), 32'd0);

    // Single word, latency and clean drain
    enable = 1'b1; bus.i_Ready = 1'b1;
    pushWords(1, 8'hA1);
    waitRx(1, 20, "t1_rx");
    settle(3);
    checkOutput("t1_data",    {24'd0, rx_data[0]}, 32'hA1);
    checkOutput("t1_rd_en_n", 32'(rd_en_count), 32'd1);
    checkOutput("t1_latency", 32'(first_pop_cycle - first_rd_cycle), 32'd2);
    checkOutput("t1_count",   32'(word_count), 32'd1);
    checkOutput("t1_busy",    32'(busy), 32'd0);
    checkOutput("t1_dv",      32'(bus.o_DV), 32'd0);
    checkOutput("t1_fifo",    32'(fifo_count), 32'd0);

    // Full FIFO at one word per cycle
    doReset();
    enable = 1'b0;
    pushWords(256, 0);
    bus.i_Ready = 1'b1; enable = 1'b1;
    waitRx(256, 400, "t2_rx");
    settle(3);
    checkStream(256, 0, "t2");
    checkOutput("t2_gapless", 32'(last_pop_cycle - first_pop_cycle), 32'd255);
    checkOutput("t2_count",   32'(word_count), 32'd256);
    checkOutput("t2_empty_rd", 32'(empty_read_err), 32'd0);
    checkOutput("t2_rd_en_n", 32'(rd_en_count), 32'd256);

    // Backpressure: two reads maximum, then toggling ready
    doReset();
    enable = 1'b1;
    pushWords(20, 8'h40);
    settle(3);
    checkOutput("t3_bp_reads", 32'(rd_en_count), 32'd2);
    checkOutput("t3_bp_dv",    32'(bus.o_DV), 32'd1);
    checkOutput("t3_bp_busy",  32'(busy), 32'd1);
    begin
      int k = 0;
      while (rx_count < 20 && k < 400) begin
        if (k % 3 == 0) bus.i_Ready = ~bus.i_Ready;
        tick();
        k++;
      end
    end
    checkOutput("t3_rx", 32'(rx_count), 32'd20);
    bus.i_Ready = 1'b1;
    settle(3);
    checkStream(20, 8'h40, "t3");
    checkOutput("t3_rd_en_n", 32'(rd_en_count), 32'd20);
    checkOutput("t3_overflow", 32'(overflow_err), 32'd0);
    checkOutput("t3_full_rd",  32'(full_read_err), 32'd0);
    checkOutput("t3_empty_rd", 32'(empty_read_err), 32'd0);

    // Framing with length 4, then a length change during a packet
    doReset();
    pkt_len = 16'd4; bus.i_Ready = 1'b1; enable = 1'b1;
    pushWords(12, 8'h80);
    waitRx(12, 40, "t4_rx12");
    settle(2);
    mask = 32'd0;
    for (int i = 0; i < 12; i++) mask[i] = rx_last[i];
    checkOutput("t4_last_mask", mask, 32'h888);
    pushWords(2, 8'h8C);
    waitRx(14, 20, "t4_rx14");
    settle(2);
    pkt_len = 16'd1;
    pushWords(6, 8'h8E);
    waitRx(20, 30, "t4_rx20");
    settle(3);
    mask = 32'd0;
    for (int i = 0; i < 8; i++) mask[i] = rx_last[12 + i];
    checkOutput("t4_len_change_mask", mask, 32'hF8);
    checkStream(20, 8'h80, "t4");
    checkOutput("t4_idle_last", 32'(bus.o_Last), 32'd0);

    // Unframed stream and counter wrap
    doReset();
    pkt_len = 16'd0; bus.i_Ready = 1'b1; enable = 1'b1;
    pushWords(10, 0);
    waitRx(10, 30, "t5_rx10");
    settle(3);
    checkOutput("t5_no_last",  32'(last_total), 32'd0);
    checkOutput("t5_count10",  32'(word_count), 32'd10);
    checkStream(10, 0, "t5");
    pushWords(65529, 10);
    waitRx(65539, 50, "t5_rx_wrap");
    settle(3);
    checkOutput("t5_wrap_count", 32'(word_count), 32'd3);
    checkOutput("t5_no_last_all", 32'(last_total), 32'd0);
    checkOutput("t5_empty_rd", 32'(empty_read_err), 32'd0);

    // Reset with a full skid buffer, then fresh traffic only
    bus.i_Ready = 1'b0;
    pushWords(5, 8'h30);
    settle(3);
    checkOutput("t6_pre_dv",   32'(bus.o_DV), 32'd1);
    checkOutput("t6_pre_occ_busy", 32'(busy), 32'd1);
    bus.i_Ready = 1'b1;
    rst_l = 1'b0;
    #1;
    checkOutput("t6_rd_en_in_rst", 32'(bus.o_Rd_En), 32'd0);
    @(posedge clk);
    #1;
    rst_l = 1'b1;
    bus.i_Ready = 1'b0;
    checkOutput("t6_dv",    32'(bus.o_DV), 32'd0);
    checkOutput("t6_last",  32'(bus.o_Last), 32'd0);
    checkOutput("t6_busy",  32'(busy), 32'd0);
    checkOutput("t6_count", 32'(word_count), 32'd0);
    checkOutput("t6_rd_en", 32'(bus.o_Rd_En), 32'd0);
    bus.i_Ready = 1'b1;
    pushWords(5, 8'h60);
    waitRx(5, 30, "t6_rx");
    settle(4);
    checkStream(5, 8'h60, "t6");
    checkOutput("t6_count5",  32'(word_count), 32'd5);
    checkOutput("t6_rx_total", 32'(rx_count), 32'd5);
    checkOutput("t6_overflow", 32'(overflow_err), 32'd0);
  endtask

  initial begin
    applyStimulus();
    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
